// File: rtl/r2_compute.sv
// r2_compute: fully pipelined binary32 squared-distance evaluator.
// dx = ref - neighbour per axis, r2 = dz*dz + (dy*dy + dx*dx), 17-cycle latency, no stalls.
// Optional macro R2_DELTA_ALIGN_EN: delay the delta outputs so they line up with r2/r2_valid.
// Only DATA_WIDTH = 32 (binary32) is supported.
module r2_compute #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] refx,
    input  logic [DATA_WIDTH-1:0] refy,
    input  logic [DATA_WIDTH-1:0] refz,
    input  logic [DATA_WIDTH-1:0] neighborx,
    input  logic [DATA_WIDTH-1:0] neighbory,
    input  logic [DATA_WIDTH-1:0] neighborz,
    output logic [DATA_WIDTH-1:0] r2,
    output logic [DATA_WIDTH-1:0] dx_out,
    output logic [DATA_WIDTH-1:0] dy_out,
    output logic [DATA_WIDTH-1:0] dz_out,
    output logic                  r2_valid
);

    localparam logic [31:0] FP_ONE = 32'h3f80_0000;

    // Right shift that ORs every shifted-out bit into the LSB (sticky jam).
    function automatic logic [75:0] shr_jam(input logic [75:0] x, input logic signed [12:0] d);
        logic [75:0] mask;
        if (d > 13'sd75) return {75'd0, |x};
        mask = (76'd1 << d[6:0]) - 76'd1;
        return (x >> d[6:0]) | {75'd0, |(x & mask)};
    endfunction

    // a*b + c with a single round-to-nearest-even; denormals flush to zero.
    // Both terms sit in a 76-bit field with 26 guard bits below the wider mantissa, so any
    // bits lost to alignment lie far below the rounding point and the jam bit stays exact.
    function automatic logic [31:0] fp_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        logic               sp, rs, rnd_up;
        logic               a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
        logic [47:0]        mp;
        logic [75:0]        xp, xc, sum, norm;
        logic signed [12:0] pe, ce, emax, diff, e_res;
        logic [6:0]         k;
        logic [24:0]        m_rnd;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        c_zero = (c[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        c_inf  = (c[30:23] == 8'hff) && (c[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        c_nan  = (c[30:23] == 8'hff) && (c[22:0] != 23'd0);
        sp     = a[31] ^ b[31];
        if (a_nan || b_nan || c_nan || (a_inf && b_zero) || (a_zero && b_inf) ||
            ((a_inf || b_inf) && c_inf && (sp != c[31]))) return 32'h7fc0_0000;
        if (a_inf || b_inf) return {sp, 8'hff, 23'd0};
        if (c_inf) return c;
        if (a_zero || b_zero) return c_zero ? {sp & c[31], 31'd0} : c;
        mp = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        // LSB exponents: product = mp * 2^(ea+eb-300), addend field = mc<<24 * 2^(ec-174)
        pe = $signed({5'd0, a[30:23]}) + $signed({5'd0, b[30:23]}) - 13'sd300;
        ce = c_zero ? pe : $signed({5'd0, c[30:23]}) - 13'sd174;
        xp = {2'd0, mp, 26'd0};
        xc = c_zero ? 76'd0 : {2'd0, 1'b1, c[22:0], 50'd0};
        if (pe >= ce) begin
            emax = pe;
            diff = pe - ce;
            xc   = shr_jam(xc, diff);
        end else begin
            emax = ce;
            diff = ce - pe;
            xp   = shr_jam(xp, diff);
        end
        if (sp == c[31]) begin
            sum = xp + xc;
            rs  = sp;
        end else if (xp >= xc) begin
            sum = xp - xc;
            rs  = sp;
        end else begin
            sum = xc - xp;
            rs  = c[31];
        end
        // Exact cancellation yields +0 under round-to-nearest-even
        if (sum == 76'd0) return 32'd0;
        k = 7'd0;
        for (int i = 0; i < 76; i++) if (sum[i]) k = 7'(i);
        norm   = sum << (7'd75 - k);
        rnd_up = norm[51] && ((|norm[50:0]) || norm[52]);
        m_rnd  = {2'b01, norm[74:52]} + 25'(rnd_up);
        e_res  = $signed({6'd0, k}) + emax + 13'sd101 + $signed({12'd0, m_rnd[24]});
        if (e_res >= 13'sd255) return {rs, 8'hff, 23'd0};
        if (e_res <= 13'sd0) return {rs, 31'd0};
        return {rs, e_res[7:0], m_rnd[22:0]};
    endfunction

    logic [16:0]           en_q;
    logic [DATA_WIDTH-1:0] dx_q [3];
    logic [DATA_WIDTH-1:0] dy_q [3];
    logic [DATA_WIDTH-1:0] dz_q [3];
    logic [DATA_WIDTH-1:0] x2_q [4];
    logic [DATA_WIDTH-1:0] dyd_q [4];
    logic [DATA_WIDTH-1:0] s_q [5];
    logic [DATA_WIDTH-1:0] dzd_q [9];
    logic [DATA_WIDTH-1:0] r2_q [5];

    // Valid shift register: only state that needs reset; outputs are gated by it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) en_q <= '0;
        else      en_q <= {en_q[15:0], enable};
    end

    // Arithmetic levels: each op feeds a delay line sized to that level's latency
    always_ff @(posedge clk) begin
        dx_q[0]  <= fp_fma(refx, FP_ONE, {~neighborx[31], neighborx[30:0]});
        dy_q[0]  <= fp_fma(refy, FP_ONE, {~neighbory[31], neighbory[30:0]});
        dz_q[0]  <= fp_fma(refz, FP_ONE, {~neighborz[31], neighborz[30:0]});
        x2_q[0]  <= fp_fma(dx_q[2], dx_q[2], 32'd0);
        dyd_q[0] <= dy_q[2];
        dzd_q[0] <= dz_q[2];
        s_q[0]   <= fp_fma(dyd_q[3], dyd_q[3], x2_q[3]);
        r2_q[0]  <= fp_fma(dzd_q[8], dzd_q[8], s_q[4]);
        for (int i = 1; i < 3; i++) begin
            dx_q[i] <= dx_q[i-1];
            dy_q[i] <= dy_q[i-1];
            dz_q[i] <= dz_q[i-1];
        end
        for (int i = 1; i < 4; i++) begin
            x2_q[i]  <= x2_q[i-1];
            dyd_q[i] <= dyd_q[i-1];
        end
        for (int i = 1; i < 5; i++) begin
            s_q[i]  <= s_q[i-1];
            r2_q[i] <= r2_q[i-1];
        end
        for (int i = 1; i < 9; i++) dzd_q[i] <= dzd_q[i-1];
    end

`ifdef R2_DELTA_ALIGN_EN
    logic [DATA_WIDTH-1:0] dxa_q [14];
    logic [DATA_WIDTH-1:0] dya_q [14];
    logic [DATA_WIDTH-1:0] dza_q [14];

    // Extra 14-cycle delta delay so deltas line up with r2
    always_ff @(posedge clk) begin
        dxa_q[0] <= dx_q[2];
        dya_q[0] <= dy_q[2];
        dza_q[0] <= dz_q[2];
        for (int i = 1; i < 14; i++) begin
            dxa_q[i] <= dxa_q[i-1];
            dya_q[i] <= dya_q[i-1];
            dza_q[i] <= dza_q[i-1];
        end
    end

    // Output gating: nothing leaks when the aligned valid is low
    always_comb begin
        r2_valid = en_q[16];
        r2       = en_q[16] ? r2_q[4] : '0;
        dx_out   = en_q[16] ? dxa_q[13] : '0;
        dy_out   = en_q[16] ? dya_q[13] : '0;
        dz_out   = en_q[16] ? dza_q[13] : '0;
    end
`else
    // Output gating: r2 by its valid, deltas by the 3-cycle-delayed enable
    always_comb begin
        r2_valid = en_q[16];
        r2       = en_q[16] ? r2_q[4] : '0;
        dx_out   = en_q[2] ? dx_q[2] : '0;
        dy_out   = en_q[2] ? dy_q[2] : '0;
        dz_out   = en_q[2] ? dz_q[2] : '0;
    end
`endif

endmodule

// File: tb/tb_r2_compute.sv
// Self-checking bench for r2_compute: scoreboard of expected results, compared when produced.
module tb_r2_compute;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] refx, refy, refz, neighborx, neighbory, neighborz;
    logic [31:0] r2, dx_out, dy_out, dz_out;
    logic        r2_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic        en;
        logic [31:0] rx, ry, rz, nx, ny, nz, r2, dx, dy, dz;
    } stim_t;

    typedef struct {
        int          t;
        logic [31:0] r2, dx, dy, dz;
    } exp_t;

    stim_t stim[$];
    exp_t  sb[$];
    exp_t  dq[$];

    r2_compute #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .refx      (refx),
        .refy      (refy),
        .refz      (refz),
        .neighborx (neighborx),
        .neighbory (neighbory),
        .neighborz (neighborz),
        .r2        (r2),
        .dx_out    (dx_out),
        .dy_out    (dy_out),
        .dz_out    (dz_out),
        .r2_valid  (r2_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact binary32 encoding of a small integer
    function automatic logic [31:0] i2f(input int v);
        int          a;
        int          msb;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        a   = (v < 0) ? -v : v;
        msb = 0;
        for (int i = 0; i < 31; i++) if (a[i]) msb = i;
        m = 32'(a) << (23 - msb);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    // Any NaN matches an expected NaN; otherwise bit-exact
    function automatic logic fp_eq(input logic [31:0] act, input logic [31:0] exp);
        if (exp[30:23] == 8'hff && exp[22:0] != 23'd0)
            return act[30:23] == 8'hff && act[22:0] != 23'd0;
        return act === exp;
    endfunction

    task automatic add_pair(input logic en, input logic [31:0] rx, ry, rz, nx, ny, nz,
                            input logic [31:0] r2e, dxe, dye, dze);
        stim_t s;
        s.en = en; s.rx = rx; s.ry = ry; s.rz = rz; s.nx = nx; s.ny = ny; s.nz = nz;
        s.r2 = r2e; s.dx = dxe; s.dy = dye; s.dz = dze;
        stim.push_back(s);
    endtask

    task automatic add_int(input int rx, ry, rz, nx, ny, nz);
        int dx, dy, dz;
        dx = rx - nx; dy = ry - ny; dz = rz - nz;
        add_pair(1'b1, i2f(rx), i2f(ry), i2f(rz), i2f(nx), i2f(ny), i2f(nz),
                 i2f(dx * dx + dy * dy + dz * dz), i2f(dx), i2f(dy), i2f(dz));
    endtask

    task automatic drive_idle();
        enable    = 1'b0;
        refx      = $urandom; refy      = $urandom; refz      = $urandom;
        neighborx = $urandom; neighbory = $urandom; neighborz = $urandom;
    endtask

    // Plays the stimulus queue one item per cycle, checking outputs as they emerge
    task automatic run_stream(input string name);
        int    n;
        exp_t  e;
        stim_t s;
        n = stim.size();
        for (int i = 0; i < n + 20; i++) begin
            @(negedge clk);
            if (r2_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s spurious_valid: r2_valid=1 r2=%h, wanted r2_valid=0",
                             name, r2);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc - e.t != 17) begin
                        errors++;
                        $display("FAIL %s latency: got %0d cycles, wanted 17", name, cyc - e.t);
                    end
                    checks++;
                    if (!fp_eq(r2, e.r2)) begin
                        errors++;
                        $display("FAIL %s r2: got %h, wanted %h", name, r2, e.r2);
                    end
`ifdef R2_DELTA_ALIGN_EN
                    checks++;
                    if (!(fp_eq(dx_out, e.dx) && fp_eq(dy_out, e.dy) && fp_eq(dz_out, e.dz))) begin
                        errors++;
                        $display("FAIL %s deltas: got %h %h %h, wanted %h %h %h", name,
                                 dx_out, dy_out, dz_out, e.dx, e.dy, e.dz);
                    end
`endif
                end
            end else begin
                checks++;
                if (r2 !== 32'd0) begin
                    errors++;
                    $display("FAIL %s r2_gap: got %h, wanted 00000000", name, r2);
                end
`ifdef R2_DELTA_ALIGN_EN
                checks++;
                if ({dx_out, dy_out, dz_out} !== 96'd0) begin
                    errors++;
                    $display("FAIL %s delta_gap: got %h %h %h, wanted 0", name,
                             dx_out, dy_out, dz_out);
                end
`endif
            end
`ifndef R2_DELTA_ALIGN_EN
            if (dq.size() > 0 && cyc - dq[0].t == 3) begin
                e = dq.pop_front();
                checks++;
                if (!(fp_eq(dx_out, e.dx) && fp_eq(dy_out, e.dy) && fp_eq(dz_out, e.dz))) begin
                    errors++;
                    $display("FAIL %s deltas: got %h %h %h, wanted %h %h %h", name,
                             dx_out, dy_out, dz_out, e.dx, e.dy, e.dz);
                end
            end else begin
                checks++;
                if ({dx_out, dy_out, dz_out} !== 96'd0) begin
                    errors++;
                    $display("FAIL %s delta_gap: got %h %h %h, wanted 0", name,
                             dx_out, dy_out, dz_out);
                end
            end
`endif
            if (i < n) begin
                s = stim[i];
                enable = s.en;
                refx = s.rx; refy = s.ry; refz = s.rz;
                neighborx = s.nx; neighbory = s.ny; neighborz = s.nz;
                if (s.en) begin
                    e.t = cyc; e.r2 = s.r2; e.dx = s.dx; e.dy = s.dy; e.dz = s.dz;
                    sb.push_back(e);
                    dq.push_back(e);
                end
            end else begin
                drive_idle();
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_results: got %0d outstanding, wanted 0", name, sb.size());
        end
        sb.delete();
        dq.delete();
        stim.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enable    = 1'b1;
        refx      = 32'h4000_0000; refy = 32'h4080_0000; refz = 32'h4100_0000;
        neighborx = 32'h3f80_0000; neighbory = 32'h3f80_0000; neighborz = 32'h3f80_0000;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (r2_valid !== 1'b0 || r2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_out: got valid=%b r2=%h, wanted 0/00000000", r2_valid, r2);
            end
            checks++;
            if ({dx_out, dy_out, dz_out} !== 96'd0) begin
                errors++;
                $display("FAIL reset_delta: got %h %h %h, wanted 0", dx_out, dy_out, dz_out);
            end
        end
        rst = 1'b1;
        drive_idle();
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (r2_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: got r2_valid=%b, wanted 0", r2_valid);
            end
        end
    endtask

    task automatic test_single();
        add_pair(1'b1, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000,
                 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000,
                 32'h426c_0000, 32'h3f80_0000, 32'h4040_0000, 32'h40e0_0000);
        run_stream("single");
    endtask

    task automatic test_back_to_back();
        add_pair(1'b1, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000,
                 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000,
                 32'h426c_0000, 32'h3f80_0000, 32'h4040_0000, 32'h40e0_0000);
        add_pair(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000,
                 32'h4040_0000, 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000);
        add_pair(1'b1, 32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000,
                 32'h4000_0000, 32'h4080_0000, 32'h4100_0000,
                 32'h426c_0000, 32'hbf80_0000, 32'hc040_0000, 32'hc0e0_0000);
        run_stream("back_to_back");
    endtask

    task automatic test_gapped();
        // Gap cycles carry live-looking data that must not leak out
        add_int(3, -2, 5, 1, 1, 1);
        add_pair(1'b0, 32'h4120_0000, 32'h4120_0000, 32'h4120_0000,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add_int(0, 4, -6, 2, 2, 2);
        add_int(-7, 1, 9, 3, -3, 4);
        add_pair(1'b0, 32'h4140_0000, 32'hc140_0000, 32'h4140_0000,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        run_stream("gapped");
    endtask

    task automatic test_edge_values();
        add_pair(1'b1, 32'h3fc0_0000, 32'hc120_0000, 32'h4049_0fdb,
                 32'h3fc0_0000, 32'hc120_0000, 32'h4049_0fdb,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        add_pair(1'b1, 32'h7f80_0000, 32'h0000_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                 32'h7f80_0000, 32'h7f80_0000, 32'h0000_0000, 32'h0000_0000);
        add_pair(1'b1, 32'h3f80_0000, 32'h7fc0_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                 32'h7fc0_0000, 32'h3f80_0000, 32'h7fc0_0000, 32'h0000_0000);
        run_stream("edge_values");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            add_int(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20,
                    int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20,
                    int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20);
        end
        run_stream("random_ints");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = 1'b1;
            refx = i2f(i + 2); refy = i2f(i + 3); refz = i2f(-i);
            neighborx = i2f(1); neighbory = i2f(-1); neighborz = i2f(2);
        end
        @(negedge clk);
        drive_idle();
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r2_valid !== 1'b0 || r2 !== 32'd0 || {dx_out, dy_out, dz_out} !== 96'd0) begin
            errors++;
            $display("FAIL reset_mid_assert: got valid=%b r2=%h d=%h %h %h, wanted all 0",
                     r2_valid, r2, dx_out, dy_out, dz_out);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) begin
            @(negedge clk);
            checks++;
            if (r2_valid !== 1'b0 || r2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_drop: got valid=%b r2=%h, wanted 0/00000000",
                         r2_valid, r2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_edge_values();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/r2_compute.md
Name: r2_compute

Overview:
- Fully pipelined IEEE-754 binary32 squared-distance evaluator for the range-limited MD force pipeline.
- Each enabled cycle accepts one reference/neighbour particle coordinate pair.
- Produces dx, dy, dz and r2 = dx²+dy²+dz² for the downstream cutoff check and force lookup.
- Throughput is one pair per clock with no stalls.

Parameters:
- DATA_WIDTH, 32, word width of coordinates and results. Only 32 (binary32) is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  marks refx..neighborz as a valid pair this cycle.
- refx, refy, refz  input  DATA_WIDTH each  reference particle position, binary32.
- neighborx, neighbory, neighborz  input  DATA_WIDTH each  neighbour particle position, binary32.
- r2  output  DATA_WIDTH  squared distance, binary32.
- dx_out, dy_out, dz_out  output  DATA_WIDTH each  coordinate deltas, binary32.
- r2_valid  output  1  r2 (and aligned deltas) valid this cycle.

Behaviour:
- Sign convention: dx = refx − neighborx, and likewise for dy and dz.
- Pipeline levels, free-running with no back-pressure:
  - L1: three parallel FP subtracts, latency 3.
  - L2: x2 = dx·dx, FP multiply, latency 4. dy and dz are delayed 4 cycles alongside.
  - L3: s = dy·dy + x2, FP multiply-add, latency 5. dz is delayed a further 5 cycles.
  - L4: r2 = dz·dz + s, FP multiply-add, latency 5.
- Total latency: a pair sampled at edge N appears on r2 at edge N+17.
- r2_valid is enable delayed by exactly 17 cycles through a 17-bit shift register.
- Back-to-back enables yield back-to-back valids, in order.
- Every cycle's inputs are processed. r2 is forced to 0 whenever r2_valid is 0, so non-enabled cycles never leak data.
- Arithmetic:
  - Round-to-nearest-even at every operation.
  - Multiply-add rounds once (fused).
  - Denormal inputs and results flush to zero.
  - Inf and NaN propagate per IEEE-754.
  - Exactly representable small integers give bit-exact results.
  - Identical ref and neighbour gives r2 = +0 (32'h00000000).
- Reset (rst low, asynchronous):
  - Valid shift register cleared; r2_valid = 0.
  - r2, dx_out, dy_out, dz_out = 0.
  - Data registers may be left unreset; output gating guarantees zero outputs.
- Reset asserted mid-stream: all in-flight pairs are dropped and no valid is emitted for them.
- After reset release, the first valid appears 17 cycles after the first enabled sample.
- Delta outputs with R2_DELTA_ALIGN_EN undefined:
  - dx/dy/dz_out come straight from the L1 subtractors, 3 cycles after the input sample.
  - Each is zeroed when the 3-cycle-delayed enable is 0.

Optional Feature:
- Macro: R2_DELTA_ALIGN_EN.
- Defined:
  - dx/dy/dz_out are delayed a further 14 cycles so they are cycle-aligned with r2 and qualified by r2_valid.
  - Zeroed when r2_valid = 0.
  - Adds three 14-deep DATA_WIDTH delay lines.
- Undefined: deltas are presented at 3-cycle latency as described in Behaviour; no extra delay lines.

Test Plan:
- Reset: hold rst low for 5 cycles with enable=1 → r2_valid=0, r2=0, all deltas 0. After release, nothing is valid until 17 cycles after the first enabled sample.
- Single pair:
  - Stimulus: ref=(2.0,4.0,8.0) = (40000000,40800000,41000000); neighbour=(1.0,1.0,1.0) = 3F800000.
  - Response: r2=426C0000 (59.0) with r2_valid exactly 17 cycles later.
  - Deltas: dx/dy/dz=3F800000/40400000/40E00000 (1,3,7), at 3 cycles (macro off) or 17 cycles (macro on).
- Back-to-back streaming:
  - Stimulus, consecutive enabled cycles: the pair above; then ref=(2,2,2), nb=(1,1,1); then ref=(1,1,1), nb=(2,4,8).
  - Response: consecutive valids 426C0000, 40400000, 426C0000.
  - Third pair deltas: BF800000, C0400000, C0E00000.
- Gapped enable: enable pattern 1,0,1,1,0 → r2_valid reproduces the same pattern shifted by 17 cycles; r2=0 in the gap cycles.
- Reset mid-stream: assert rst 8 cycles after 4 enabled pairs → no valid is ever emitted for those pairs; outputs are 0 immediately on assertion.
- Edge values:
  - ref == neighbour → r2=00000000, valid.
  - ref=(+Inf,0,0) → r2=7F800000.
  - A NaN coordinate → NaN r2.
